// File: rtl/player_sprite_pkg.sv
// Shared definitions for the player sprite slots: sprite geometry, the fixed
// colour palette and the bus register offsets.
package player_sprite_pkg;

  localparam int SPR_W = 32;
  localparam int SPR_H = 64;

  localparam logic [1:0] REG_X0    = 2'd0;
  localparam logic [1:0] REG_Y0    = 2'd1;
  localparam logic [1:0] REG_CTRL  = 2'd2;
  localparam logic [1:0] REG_FLASH = 2'd3;

  // Element 0 is the transparent index and never reaches the output.
  localparam logic [7:0][11:0] PALETTE = {
    12'hFFF, 12'hF0F, 12'h0FF, 12'hFF0,
    12'h00F, 12'h0F0, 12'hF00, 12'h000
  };

endpackage

// File: rtl/player_sprite_hit.sv
// Combinational hit test and sprite RAM read address for one 32x64 sprite.
// Shared by both player slots.
module player_sprite_hit
  import player_sprite_pkg::*;
(
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic [10:0] x0,
  input  logic [10:0] y0,
  input  logic        enable,
  input  logic        hide,
  input  logic        flip_h,
  output logic        hit,
  output logic [10:0] ram_addr
);

  logic [11:0] dx;
  logic [11:0] dy;
  logic [4:0]  col;
  logic        in_box;

  assign dx = {1'b0, x} - {1'b0, x0};
  assign dy = {1'b0, y} - {1'b0, y0};

  // A zero upper field means 0 <= d < size; negatives carry the sign bit.
  assign in_box = (dx[11:5] == 7'd0) && (dy[11:6] == 6'd0);
  assign hit    = enable & ~hide & in_box;

  assign col      = flip_h ? (5'd31 - dx[4:0]) : dx[4:0];
  assign ram_addr = {dy[5:0], col};

endmodule

// File: rtl/player2_sprite_core.sv
// Player-2 sprite slot: bus-programmed position/control with frame-synchronous
// commit, flash blink, sprite RAM addressing and a 2-stage colour overlay.
module player2_sprite_core
  import player_sprite_pkg::*;
#(
  parameter int CD      = 12,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 3,
  parameter int KEY_IDX = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       x,
  input  logic [10:0]       y,
  input  logic              frame_start,
  input  logic              cs,
  input  logic              write,
  input  logic [13:0]       addr,
  input  logic [31:0]       wr_data,
  input  logic [CD-1:0]     si_rgb,
  output logic [ADDR_W-1:0] ram_addr_r,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr_w,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [CD-1:0]     so_rgb
);

  logic        bus_wr;
  logic        reg_wr;
  logic        hit;
  logic        hide;
  logic [10:0] hit_addr;

  logic [10:0] x0_pend_q, x0_pend_d, y0_pend_q, y0_pend_d;
  logic [1:0]  ctrl_pend_q, ctrl_pend_d;
  logic [10:0] x0_act_q, x0_act_d, y0_act_q, y0_act_d;
  logic [1:0]  ctrl_act_q, ctrl_act_d;
  logic [5:0]  flash_cnt_q, flash_cnt_d;
  logic        hit_d1_q, hit_d1_d;
  logic [CD-1:0] si_d1_q, si_d1_d;
  logic [CD-1:0] so_rgb_q, so_rgb_d;

  logic unused_bus_bits;
  assign unused_bus_bits = &{1'b0, addr[12:11], wr_data[31:11]};

  assign bus_wr     = cs & write;
  assign reg_wr     = bus_wr & addr[13];
  assign ram_we     = bus_wr & ~addr[13];
  assign ram_addr_w = addr[ADDR_W-1:0];
  assign ram_din    = wr_data[DATA_W-1:0];

  assign hide = (flash_cnt_q != 6'd0) & flash_cnt_q[2];

  player_sprite_hit u_hit (
    .x        (x),
    .y        (y),
    .x0       (x0_act_q),
    .y0       (y0_act_q),
    .enable   (ctrl_act_q[0]),
    .hide     (hide),
    .flip_h   (ctrl_act_q[1]),
    .hit      (hit),
    .ram_addr (hit_addr)
  );

  assign ram_addr_r = hit_addr;
  assign so_rgb     = so_rgb_q;

  always_comb begin
    x0_pend_d   = x0_pend_q;
    y0_pend_d   = y0_pend_q;
    ctrl_pend_d = ctrl_pend_q;
    x0_act_d    = x0_act_q;
    y0_act_d    = y0_act_q;
    ctrl_act_d  = ctrl_act_q;
    flash_cnt_d = flash_cnt_q;

    if (reg_wr) begin
      case (addr[1:0])
        REG_X0:   x0_pend_d   = wr_data[10:0];
        REG_Y0:   y0_pend_d   = wr_data[10:0];
        REG_CTRL: ctrl_pend_d = wr_data[1:0];
        default:  ;
      endcase
    end

    // Commit uses the pending value from before any same-cycle write.
    if (frame_start) begin
      x0_act_d   = x0_pend_q;
      y0_act_d   = y0_pend_q;
      ctrl_act_d = ctrl_pend_q;
    end

    if (reg_wr && addr[1:0] == REG_FLASH) begin
      flash_cnt_d = wr_data[5:0];
    end else if (frame_start && flash_cnt_q != 6'd0) begin
      flash_cnt_d = flash_cnt_q - 6'd1;
    end

    hit_d1_d = hit;
    si_d1_d  = si_rgb;

    if (hit_d1_q && ram_dout != DATA_W'(KEY_IDX)) begin
      so_rgb_d = CD'(PALETTE[ram_dout]);
    end else begin
      so_rgb_d = si_d1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x0_pend_q   <= '0;
      y0_pend_q   <= '0;
      ctrl_pend_q <= '0;
      x0_act_q    <= '0;
      y0_act_q    <= '0;
      ctrl_act_q  <= '0;
      flash_cnt_q <= '0;
      hit_d1_q    <= 1'b0;
      si_d1_q     <= '0;
      so_rgb_q    <= '0;
    end else begin
      x0_pend_q   <= x0_pend_d;
      y0_pend_q   <= y0_pend_d;
      ctrl_pend_q <= ctrl_pend_d;
      x0_act_q    <= x0_act_d;
      y0_act_q    <= y0_act_d;
      ctrl_act_q  <= ctrl_act_d;
      flash_cnt_q <= flash_cnt_d;
      hit_d1_q    <= hit_d1_d;
      si_d1_q     <= si_d1_d;
      so_rgb_q    <= so_rgb_d;
    end
  end

endmodule
